// File: rtl/ibuf_load_ctrl_if.sv
// Handshake bundle between the index-buffer load controller and its
// neighbours: the task source, the ddr2ibuf configuration port and the
// DDR read-command port. The controller takes the master view.
interface ibuf_load_ctrl_if #(
   parameter int PE_NUM = 32,
   parameter int ADDR_W = 32
);
   // task descriptor
   logic              task_valid;
   logic              task_ready;
   logic [3:0]        task_mode;
   logic [7:0]        task_idx_num;
   logic [PE_NUM-1:0] task_pe_mask;
   logic              task_bcast;
   logic [ADDR_W-1:0] task_base;
   logic [ADDR_W-1:0] task_stride;
   // ddr2ibuf configuration
   logic              conf_valid;
   logic              conf_ready;
   logic [3:0]        conf_mode;
   logic [7:0]        conf_idx_num;
   logic [PE_NUM-1:0] conf_mask;
   // DDR read command
   logic              rd_cmd_valid;
   logic              rd_cmd_ready;
   logic [ADDR_W-1:0] rd_cmd_addr;
   logic [7:0]        rd_cmd_len;
   // status
   logic              busy;
   logic              done;

   modport master (
      input  task_valid, task_mode, task_idx_num, task_pe_mask, task_bcast,
             task_base, task_stride, conf_ready, rd_cmd_ready,
      output task_ready, conf_valid, conf_mode, conf_idx_num, conf_mask,
             rd_cmd_valid, rd_cmd_addr, rd_cmd_len, busy, done
   );

   modport slave (
      output task_valid, task_mode, task_idx_num, task_pe_mask, task_bcast,
             task_base, task_stride, conf_ready, rd_cmd_ready,
      input  task_ready, conf_valid, conf_mode, conf_idx_num, conf_mask,
             rd_cmd_valid, rd_cmd_addr, rd_cmd_len, busy, done
   );
endinterface

// File: rtl/ibuf_load_ctrl.sv
// Index-buffer load controller. Accepts one task descriptor, then for each
// selected PE (ascending index) configures ddr2ibuf, issues one DDR read and
// waits for ddr2ibuf to go idle again. Broadcast tasks issue a single load
// written into every masked PE. All outputs are registered.
module ibuf_load_ctrl #(
   parameter int PE_NUM = 32,
   parameter int ADDR_W = 32,
   parameter int DDR_W  = 64,
   parameter int IDX_W  = 8
) (
   input logic clk,
   input logic rst,
   ibuf_load_ctrl_if.master bus
);

   // indices carried per DDR beat
   localparam int IDX_BATCH = DDR_W / (2 * IDX_W);
   localparam int BATCH_SH  = $clog2(IDX_BATCH);
   localparam int PIDX_W    = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PICK,
      S_CONF,
      S_CMD,
      S_WAIT,
      S_DONE
   } state_t;

   state_t state;

   // latched task descriptor
   logic [3:0]        mode_q;
   logic [7:0]        idx_num_q;
   logic [PE_NUM-1:0] mask_q;
   logic              bcast_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] stride_q;

   // PEs still waiting for their load
   logic [PE_NUM-1:0] rem_mask;

   // next load target derived from the remaining mask
   logic [PIDX_W-1:0] pick_idx;
   logic [PE_NUM-1:0] pick_onehot;
   logic [ADDR_W-1:0] pick_addr;

   // Beats needed for n indices: ceil(n / IDX_BATCH), kept in 8 bits.
   // A 9-bit sum keeps n=255 from wrapping before the shift.
   function automatic logic [7:0] ceil_len(input logic [7:0] n);
      logic [8:0] sum;
      sum = {1'b0, n} + 9'(IDX_BATCH - 1);
      return 8'(sum >> BATCH_SH);
   endfunction

   // Index of the lowest set bit of a mask (0 when the mask is empty).
   function automatic logic [PIDX_W-1:0] lowest_idx(input logic [PE_NUM-1:0] m);
      logic [PIDX_W-1:0] r;
      r = '0;
      for (int i = PE_NUM - 1; i >= 0; i--) begin
         if (m[i]) r = PIDX_W'(i);
      end
      return r;
   endfunction

   // Select the lowest pending PE and its block address (wraps modulo 2^ADDR_W).
   always_comb begin
      pick_idx    = lowest_idx(rem_mask);
      pick_onehot = rem_mask & (~rem_mask + PE_NUM'(1));
      pick_addr   = base_q + ADDR_W'(pick_idx) * stride_q;
   end

   // Task sequencer: one load per PE (or one broadcast load) per task.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         bus.task_ready   <= 1'b1;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.conf_valid   <= 1'b0;
         bus.rd_cmd_valid <= 1'b0;
         bus.conf_mode    <= '0;
         bus.conf_idx_num <= '0;
         bus.conf_mask    <= '0;
         bus.rd_cmd_addr  <= '0;
         bus.rd_cmd_len   <= '0;
         rem_mask         <= '0;
         mode_q           <= '0;
         idx_num_q        <= '0;
         mask_q           <= '0;
         bcast_q          <= 1'b0;
         base_q           <= '0;
         stride_q         <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.task_valid && bus.task_ready) begin
                  mode_q         <= bus.task_mode;
                  idx_num_q      <= bus.task_idx_num;
                  mask_q         <= bus.task_pe_mask;
                  bcast_q        <= bus.task_bcast;
                  base_q         <= bus.task_base;
                  stride_q       <= bus.task_stride;
                  rem_mask       <= bus.task_pe_mask;
                  bus.task_ready <= 1'b0;
                  bus.busy       <= 1'b1;
                  state          <= S_PICK;
               end
            end

            S_PICK: begin
               if (idx_num_q == 8'd0 || rem_mask == '0) begin
                  bus.done <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  bus.conf_mode    <= mode_q;
                  bus.conf_idx_num <= idx_num_q;
                  bus.conf_mask    <= bcast_q ? mask_q : pick_onehot;
                  bus.rd_cmd_addr  <= bcast_q ? base_q : pick_addr;
                  bus.rd_cmd_len   <= ceil_len(idx_num_q);
                  bus.conf_valid   <= 1'b1;
                  state            <= S_CONF;
               end
            end

            S_CONF: begin
               // the read is only raised once ddr2ibuf has taken its config
               if (bus.conf_ready) begin
                  bus.conf_valid   <= 1'b0;
                  bus.rd_cmd_valid <= 1'b1;
                  state            <= S_CMD;
               end
            end

            S_CMD: begin
               if (bus.rd_cmd_ready) begin
                  bus.rd_cmd_valid <= 1'b0;
                  state            <= S_WAIT;
               end
            end

            S_WAIT: begin
               // ddr2ibuf back to idle means this load has landed
               if (bus.conf_ready) begin
                  rem_mask <= bcast_q ? '0 : (rem_mask & ~bus.conf_mask);
                  state    <= S_PICK;
               end
            end

            S_DONE: begin
               bus.done       <= 1'b0;
               bus.busy       <= 1'b0;
               bus.task_ready <= 1'b1;
               state          <= S_IDLE;
            end

            default: begin
               bus.done         <= 1'b0;
               bus.busy         <= 1'b0;
               bus.task_ready   <= 1'b1;
               bus.conf_valid   <= 1'b0;
               bus.rd_cmd_valid <= 1'b0;
               state            <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ibuf_load_ctrl.sv
// Bench for ibuf_load_ctrl: directed tasks, a list-of-loads reference model
// and a per-cycle monitor, plus literal expectations for key vectors.
module tb_ibuf_load_ctrl;
   localparam int PE_NUM    = 32;
   localparam int ADDR_W    = 32;
   localparam int DDR_W     = 64;
   localparam int IDX_W     = 8;
   localparam int IDX_BATCH = DDR_W / (2 * IDX_W);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ibuf_load_ctrl_if #(.PE_NUM(PE_NUM), .ADDR_W(ADDR_W)) bus ();

   ibuf_load_ctrl #(
      .PE_NUM(PE_NUM), .ADDR_W(ADDR_W), .DDR_W(DDR_W), .IDX_W(IDX_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [3:0]  mode;
      logic [7:0]  idx;
      logic [31:0] mask;
      logic [31:0] addr;
      logic [7:0]  len;
   } load_t;

   load_t       exp_q[$];
   logic [31:0] obs_mask[$];
   logic [31:0] obs_addr[$];
   logic [7:0]  obs_len[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int done_cnt = 0, done_cyc = 0, accept_cyc = 0, cmd_hs_cnt = 0;
   int cv_cnt = 0, rv_cnt = 0;
   int rdy_mode = 0;
   bit pend = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   function automatic logic [31:0] om(input int i);
      return (i < obs_mask.size()) ? obs_mask[i] : 32'hx;
   endfunction
   function automatic logic [31:0] oa(input int i);
      return (i < obs_addr.size()) ? obs_addr[i] : 32'hx;
   endfunction
   function automatic logic [7:0] ol(input int i);
      return (i < obs_len.size()) ? obs_len[i] : 8'hx;
   endfunction

   // Reference: list of loads a task must produce, in issue order.
   function automatic logic [7:0] model_len(input int n);
      return 8'((n + IDX_BATCH - 1) / IDX_BATCH);
   endfunction

   task automatic model_task(input logic [3:0] mode, input logic [7:0] idx,
                             input logic [31:0] mask, input logic bc,
                             input logic [31:0] base, input logic [31:0] stride);
      load_t e;
      if (idx == 8'd0 || mask == 32'd0) return;
      e.mode = mode;
      e.idx  = idx;
      e.len  = model_len(int'(idx));
      if (bc) begin
         e.mask = mask;
         e.addr = base;
         exp_q.push_back(e);
      end else begin
         for (int p = 0; p < PE_NUM; p++) begin
            if (mask[p]) begin
               e.mask = 32'd1 << p;
               e.addr = base + 32'(p) * stride;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   // Ready generation: always ready, scripted stalls, or random backpressure.
   initial begin
      bit hs;
      int wait_lo, rd_lo;
      wait_lo = 0;
      rd_lo   = 0;
      bus.conf_ready   = 1'b1;
      bus.rd_cmd_ready = 1'b1;
      forever begin
         @(negedge clk);
         hs = bus.rd_cmd_valid && bus.rd_cmd_ready;
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: begin
               if (hs) wait_lo = 20;
               if (wait_lo > 0) begin
                  bus.conf_ready = 1'b0;
                  wait_lo--;
               end else bus.conf_ready = 1'b1;
               if (bus.rd_cmd_valid && rd_lo < 5) begin
                  bus.rd_cmd_ready = 1'b0;
                  rd_lo++;
               end else if (bus.rd_cmd_valid) bus.rd_cmd_ready = 1'b1;
               else begin
                  bus.rd_cmd_ready = 1'b0;
                  rd_lo = 0;
               end
            end
            2: begin
               bus.conf_ready   = ($urandom_range(0, 3) != 0);
               bus.rd_cmd_ready = ($urandom_range(0, 1) == 1);
               wait_lo = 0;
               rd_lo   = 0;
            end
            default: begin
               bus.conf_ready   = 1'b1;
               bus.rd_cmd_ready = 1'b1;
               wait_lo = 0;
               rd_lo   = 0;
            end
         endcase
      end
   end

   // Monitor: protocol rules every cycle, handshakes against the model.
   initial begin
      logic p_cv, p_cr, p_rv, p_rr, p_done;
      logic [3:0]  p_mode;
      logic [7:0]  p_idx, p_len;
      logic [31:0] p_mask, p_addr;
      bit seen_cr;
      load_t e, pend_e;
      p_cv = 0; p_cr = 0; p_rv = 0; p_rr = 0; p_done = 0;
      p_mode = 0; p_idx = 0; p_len = 0; p_mask = 0; p_addr = 0;
      seen_cr = 1;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            pend = 0; seen_cr = 1; p_cv = 0; p_rv = 0; p_done = 0;
            continue;
         end
         chk("ready_vs_busy", 64'(bus.task_ready), 64'(!bus.busy));
         chk("valid_exclusive", 64'(bus.conf_valid & bus.rd_cmd_valid), 64'(0));
         if (bus.conf_valid) cv_cnt++;
         if (bus.rd_cmd_valid) rv_cnt++;
         if (bus.done) begin
            chk("done_one_cycle", 64'(p_done), 64'(0));
            chk("done_while_busy", 64'(bus.busy), 64'(1));
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.task_valid && bus.task_ready) accept_cyc = cyc;
         if (p_cv && !p_cr)
            chk("conf_hold", {27'd0, bus.conf_valid, bus.conf_mode, bus.conf_idx_num, bus.conf_mask},
                {27'd0, 1'b1, p_mode, p_idx, p_mask});
         if (p_rv && !p_rr)
            chk("cmd_hold", {23'd0, bus.rd_cmd_valid, bus.rd_cmd_addr, bus.rd_cmd_len},
                {23'd0, 1'b1, p_addr, p_len});
         if (bus.conf_valid && !p_cv) chk("conf_after_idle_seen", 64'(seen_cr), 64'(1));
         if (bus.conf_valid && bus.conf_ready) begin
            obs_mask.push_back(bus.conf_mask);
            chk("conf_while_read_pending", 64'(pend), 64'(0));
            chk("conf_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("conf_mode", 64'(bus.conf_mode), 64'(e.mode));
               chk("conf_idx_num", 64'(bus.conf_idx_num), 64'(e.idx));
               chk("conf_mask", 64'(bus.conf_mask), 64'(e.mask));
               pend   = 1;
               pend_e = e;
            end
         end
         if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
            cmd_hs_cnt++;
            obs_addr.push_back(bus.rd_cmd_addr);
            obs_len.push_back(bus.rd_cmd_len);
            chk("cmd_after_conf", 64'(pend), 64'(1));
            if (pend) begin
               chk("rd_cmd_addr", 64'(bus.rd_cmd_addr), 64'(pend_e.addr));
               chk("rd_cmd_len", 64'(bus.rd_cmd_len), 64'(pend_e.len));
            end
            pend    = 0;
            seen_cr = 0;
         end else if (bus.conf_ready) seen_cr = 1;
         p_cv = bus.conf_valid; p_cr = bus.conf_ready;
         p_rv = bus.rd_cmd_valid; p_rr = bus.rd_cmd_ready;
         p_done = bus.done;
         p_mode = bus.conf_mode; p_idx = bus.conf_idx_num; p_mask = bus.conf_mask;
         p_addr = bus.rd_cmd_addr; p_len = bus.rd_cmd_len;
      end
   end

   // Present a task, hold until accepted, then scramble the task inputs.
   task automatic launch(input logic [3:0] mode, input logic [7:0] idx,
                         input logic [31:0] mask, input logic bc,
                         input logic [31:0] base, input logic [31:0] stride);
      bit ok;
      ok = 0;
      exp_q.delete();
      model_task(mode, idx, mask, bc, base, stride);
      obs_mask.delete(); obs_addr.delete(); obs_len.delete();
      done_cnt = 0; cv_cnt = 0; rv_cnt = 0;
      bus.task_mode = mode; bus.task_idx_num = idx; bus.task_pe_mask = mask;
      bus.task_bcast = bc; bus.task_base = base; bus.task_stride = stride;
      bus.task_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.task_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.task_valid   = 1'b0;
      bus.task_mode    = 4'($urandom);
      bus.task_idx_num = 8'($urandom);
      bus.task_pe_mask = $urandom;
      bus.task_bcast   = 1'($urandom);
      bus.task_base    = $urandom;
      bus.task_stride  = $urandom;
      chk("task_accepted", 64'(ok), 64'(1));
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      chk({tag, "_done_seen"}, 64'(seen), 64'(1));
      chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
      chk({tag, "_all_loads_issued"}, 64'(exp_q.size()), 64'(0));
      chk({tag, "_no_read_pending"}, 64'(pend), 64'(0));
   endtask

   initial begin
      int prev_done, base_hs;
      bus.task_valid = 0; bus.task_mode = 0; bus.task_idx_num = 0;
      bus.task_pe_mask = 0; bus.task_bcast = 0; bus.task_base = 0; bus.task_stride = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_task_ready", 64'(bus.task_ready), 64'(1));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_conf_valid", 64'(bus.conf_valid), 64'(0));
      chk("rst_rd_cmd_valid", 64'(bus.rd_cmd_valid), 64'(0));
      chk("rst_conf_fields", {bus.conf_mode, bus.conf_idx_num, bus.conf_mask}, 64'(0));
      chk("rst_cmd_fields", {bus.rd_cmd_addr, bus.rd_cmd_len}, 64'(0));
      @(posedge clk);
      #1;

      // two PEs, one load each, ascending
      launch(4'h3, 8'd10, 32'h0000_0005, 1'b0, 32'h1000, 32'h40);
      wait_done("pe0_pe2", 300);
      chk("pe0_pe2_loads", 64'(obs_mask.size()), 64'(2));
      chk("pe0_pe2_mask0", 64'(om(0)), 64'h1);
      chk("pe0_pe2_addr0", 64'(oa(0)), 64'h1000);
      chk("pe0_pe2_len0", 64'(ol(0)), 64'd3);
      chk("pe0_pe2_mask1", 64'(om(1)), 64'h4);
      chk("pe0_pe2_addr1", 64'(oa(1)), 64'h1080);
      chk("pe0_pe2_len1", 64'(ol(1)), 64'd3);

      // broadcast, back-to-back with the previous task
      prev_done = done_cyc;
      launch(4'h3, 8'd10, 32'h0000_0005, 1'b1, 32'h1000, 32'h40);
      chk("b2b_accept_after_done", 64'(accept_cyc - prev_done), 64'd1);
      wait_done("bcast", 300);
      chk("bcast_loads", 64'(obs_addr.size()), 64'd1);
      chk("bcast_mask", 64'(om(0)), 64'h5);
      chk("bcast_addr", 64'(oa(0)), 64'h1000);
      chk("bcast_len", 64'(ol(0)), 64'd3);

      // empty mask and zero index count finish without any load
      launch(4'h1, 8'd10, 32'h0, 1'b0, 32'h1000, 32'h40);
      wait_done("mask0", 50);
      chk("mask0_done_latency", 64'(done_cyc - accept_cyc), 64'd2);
      chk("mask0_no_conf", 64'(cv_cnt), 64'd0);
      chk("mask0_no_cmd", 64'(rv_cnt), 64'd0);
      launch(4'h1, 8'd0, 32'h0000_00F0, 1'b0, 32'h1000, 32'h40);
      wait_done("idx0", 50);
      chk("idx0_done_latency", 64'(done_cyc - accept_cyc), 64'd2);
      chk("idx0_no_conf", 64'(cv_cnt), 64'd0);
      chk("idx0_no_cmd", 64'(rv_cnt), 64'd0);

      // top PE: plain and wrapping address arithmetic
      launch(4'h2, 8'd7, 32'h8000_0000, 1'b0, 32'hFFFF_FFC0, 32'h2);
      wait_done("pe31", 300);
      chk("pe31_addr", 64'(oa(0)), 64'hFFFF_FFFE);
      chk("pe31_len", 64'(ol(0)), 64'd2);
      launch(4'h2, 8'd7, 32'h8000_0000, 1'b0, 32'hFFFF_FFC4, 32'h2);
      wait_done("pe31_wrap", 300);
      chk("pe31_wrap_addr", 64'(oa(0)), 64'h0000_0002);

      // long stalls in CMD and WAIT
      rdy_mode = 1;
      launch(4'h9, 8'd10, 32'h0000_0106, 1'b0, 32'h2000, 32'h10);
      wait_done("stall", 800);
      chk("stall_loads", 64'(obs_addr.size()), 64'd3);
      chk("stall_addr2", 64'(oa(2)), 64'h2080);

      // reset while waiting on the second PE
      base_hs = cmd_hs_cnt;
      launch(4'h4, 8'd10, 32'h0000_0005, 1'b0, 32'h1000, 32'h40);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cmd_hs_cnt - base_hs >= 2) break;
      end
      chk("rst_test_reached_wait", 64'(cmd_hs_cnt - base_hs), 64'd2);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_mode = 0;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_task_ready", 64'(bus.task_ready), 64'(1));
      chk("midrst_busy", 64'(bus.busy), 64'(0));
      chk("midrst_valids", {bus.conf_valid, bus.rd_cmd_valid}, 64'(0));
      chk("midrst_done", 64'(bus.done), 64'(0));
      repeat (20) @(negedge clk);
      chk("midrst_no_done", 64'(done_cnt), 64'(0));
      @(posedge clk);
      #1;
      launch(4'h4, 8'd10, 32'h0000_0005, 1'b0, 32'h1000, 32'h40);
      wait_done("after_rst", 300);
      chk("after_rst_addr1", 64'(oa(1)), 64'h1080);

      // random backpressure
      rdy_mode = 2;
      launch(4'h5, 8'd255, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h100);
      wait_done("all32", 4000);
      chk("all32_loads", 64'(obs_mask.size()), 64'd32);
      chk("all32_len", 64'(ol(0)), 64'd64);
      chk("all32_last_addr", 64'(oa(31)), 64'h1F00);
      launch(4'hA, 8'd1, 32'h8000_0001, 1'b1, 32'h4000, 32'h40);
      wait_done("bcast_ends", 400);
      chk("bcast_ends_mask", 64'(om(0)), 64'h8000_0001);
      chk("bcast_ends_len", 64'(ol(0)), 64'd1);
      launch(4'h6, 8'd5, 32'h0001_0010, 1'b0, 32'h10, 32'hFFFF_FFF0);
      wait_done("neg_stride", 400);
      rdy_mode = 0;

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
      $fatal(1, "timeout");
   end

endmodule
